enable_handshake_tx: RTL and testbench
======================================

Name: enable_handshake_tx

Overview:
- Source-side end of the enable-crossing path: the transmitter that feeds an enable synchronizer in another clock domain.
- Converts single-cycle enable pulses into a four-phase req/ack handshake.
- Queues bursts as a saturating pending count.
- The ack return from the far domain is asynchronous and is synchronized internally.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on ack_in; legal range 2..4.
- CNT_W, 4: width of the pending-pulse counter.
- TIMEOUT_CYCLES, 1023: clk cycles allowed per handshake phase (used only with HS_TIMEOUT_EN).

Ports:
- clk  input  1  single clock for the block.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- pulse_in  input  1  one-cycle enable request, synchronous to clk.
- ack_in  input  1  acknowledge from the far domain; asynchronous to clk.
- req_out  output  1  registered handshake request; drives the far-domain synchronizer.
- busy  output  1  high while state != IDLE.
- pending  output  CNT_W  pulses accepted but not yet launched.
- overflow  output  1  sticky; a pulse was lost because pending was saturated.
- timeout  output  1  sticky; a handshake phase exceeded TIMEOUT_CYCLES (0 when feature off).

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE; req_out=0, busy=0, pending=0, overflow=0, timeout=0.
  - Sync chain and phase counter cleared.
  - Takes effect immediately, including mid-handshake: req_out drops without waiting for ack.
- ack_s: ack_in after SYNC_STAGES flops. Only ack_s is used by logic.
- FSM, all registered, one transition per edge:
  - IDLE: if pulse_in=1 or pending>0, go to REQ and set req_out=1 on the same edge. A pulse at edge k gives req_out=1 after edge k.
  - REQ: hold req_out=1; when ack_s=1, go to RELEASE and set req_out=0.
  - RELEASE: hold req_out=0; when ack_s=0, go to IDLE.
  - Back-to-back launches: with pending>0 in IDLE, REQ is re-entered on the next edge, giving a one-cycle IDLE gap between handshakes.
- Pending counter:
  - Increments on pulse_in, except when the pulse is consumed by a direct IDLE->REQ launch with pending=0 (bypass).
  - Decrements on every IDLE->REQ launch with pending>0.
  - Increment and decrement on the same edge leave it unchanged.
  - Saturates at 2^CNT_W-1. A further pulse is dropped and sets overflow=1 (sticky until reset).
- Phase durations: no per-phase minimum beyond ack_s latency. Round trip is at least 2*SYNC_STAGES+2 cycles plus far-side latency.
- Unexpected ack: ack_s=1 while in IDLE is ignored; the next REQ waits for ack_s=1 as normal.

Optional Feature:
- Macro: HS_TIMEOUT_EN.
- When defined:
  - A phase counter clears on entry to REQ and to RELEASE, and increments each cycle spent in either state.
  - Reaching TIMEOUT_CYCLES sets timeout=1 (sticky), forces req_out=0 and returns to IDLE.
  - The lost handshake is not retried; pending is unaffected, so queued pulses continue.
- When undefined:
  - No phase counter is built; timeout is tied to 0.
  - REQ and RELEASE wait indefinitely.

Decomposition:
- Package enable_sync_pkg:
  - typedef enum logic [1:0] hs_state_t {IDLE, REQ, RELEASE}.
  - Default constants DEF_SYNC_STAGES=2 and DEF_TIMEOUT=1023.
  - The receive-side block shares the package.
- Sub-module bit_sync: parameterised SYNC_STAGES flop chain, with asynchronous active-low reset, for ack_in. Reusable on the receive side for req.

Test Plan:
- 32 MHz clk (15.625 ns half-period) throughout; the bench models the far side as an ack loopback that echoes req_out after 3 cycles.
- Reset sequence: hold reset=0 for 5 cycles, then release -> all outputs 0; a single pulse_in then gives req_out=1 after the next edge, busy=1, one full handshake, return to IDLE with pending=0.
- Burst: 5 consecutive pulse_in cycles -> pending climbs to 4 (first pulse bypassed), exactly 5 req_out rising edges, pending=0 at the end, overflow=0.
- Saturation with CNT_W=4: 20 pulses while ack_in is held at 0 -> pending=15, overflow=1; release ack -> exactly 16 handshakes.
- Simultaneous events: pulse_in on the same edge as an IDLE->REQ launch from pending=3 -> pending stays 3.
- Reset mid-REQ: drive reset=0 while req_out=1 -> req_out=0 within the same timestep (asynchronous), pending=0; after release with no pulses, no req.
- HS_TIMEOUT_EN with TIMEOUT_CYCLES=20: ack_in stuck at 0 -> timeout=1 after 20 REQ cycles, req_out=0, state IDLE; a following pulse still launches a new REQ.

Source files
------------

// File: rtl/enable_sync_pkg.sv
// -----------------------------------------------------------------------------
// enable_sync_pkg
//   Shared definitions for both ends of the enable-crossing path: the source
//   side (enable_handshake_tx) and the receive-side synchronizer.
//
//   Contents:
//     hs_state_t       four-phase handshake state (IDLE, REQ, RELEASE)
//     DEF_SYNC_STAGES  default depth of an ack/req synchronizer chain
//     DEF_TIMEOUT      default clk cycles allowed per handshake phase
//     DEF_CNT_W        default width of the pending-pulse counter
//     phase_cnt_w()    width needed for a phase counter counting 0..t
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package enable_sync_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } hs_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 1023;
  localparam int DEF_CNT_W       = 4;

  // Width of a counter that must be able to hold values 0..t.
  function automatic int phase_cnt_w(input int t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
//   Multi-flop synchronizer for a single level signal arriving from another
//   clock domain. Used for ack on the transmit side and for req on the
//   receive side.
//
//   Parameters:
//     SYNC_STAGES  number of flops in the chain (legal 2..4)
//
//   Ports:
//     clk    in   destination-domain clock
//     reset  in   asynchronous active-low reset (0 = in reset), clears chain
//     d      in   asynchronous input level
//     q      out  synchronized level, SYNC_STAGES clk edges after d
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module bit_sync
  import enable_sync_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_reg;

  // First stage samples the asynchronous input; it may go metastable and is
  // never used by anything except the next stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg[0] <= 1'b0;
    end else begin
      sync_reg[0] <= d;
    end
  end

  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_reg[gi] <= 1'b0;
      end else begin
        sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  end

  assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/enable_handshake_tx.sv
// -----------------------------------------------------------------------------
// enable_handshake_tx
//   Source-side end of the enable-crossing path. Turns single-cycle enable
//   pulses into four-phase req/ack handshakes toward a synchronizer in another
//   clock domain. Pulses that arrive while a handshake is in flight are queued
//   in a saturating pending counter and launched back to back.
//
//   Optional feature (compile-time macro HS_TIMEOUT_EN):
//     defined   - each handshake phase is limited to TIMEOUT_CYCLES clk cycles;
//                 expiry sets sticky timeout, drops req_out and returns to
//                 IDLE without retrying the lost handshake.
//     undefined - no phase counter; REQ/RELEASE wait indefinitely, timeout=0.
//
//   Parameters:
//     SYNC_STAGES     flops on ack_in (2..4)
//     CNT_W           width of the pending counter
//     TIMEOUT_CYCLES  cycles allowed per phase (HS_TIMEOUT_EN only)
//
//   Ports:
//     clk       in   block clock
//     reset     in   asynchronous active-low reset (0 = in reset)
//     pulse_in  in   one-cycle enable request, synchronous to clk
//     ack_in    in   acknowledge from far domain, asynchronous to clk
//     req_out   out  registered handshake request
//     busy      out  high while a handshake is in progress (state != IDLE)
//     pending   out  pulses accepted but not yet launched
//     overflow  out  sticky: a pulse was dropped with pending saturated
//     timeout   out  sticky: a handshake phase expired (0 when feature off)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module enable_handshake_tx
  import enable_sync_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic             ack_in,
  output logic             req_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  logic             ack_s;
  hs_state_t        state_reg;
  logic             req_reg;
  logic [CNT_W-1:0] pending_reg;
  logic [CNT_W-1:0] pending_next;
  logic             overflow_reg;
  logic             overflow_next;
  logic             launch;
  logic             pend_inc;
  logic             pend_dec;
  logic             hs_advance;
  logic             phase_expired;

  bit_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ack_in),
    .q     (ack_s)
  );

  // A launch happens from IDLE whenever there is work: a fresh pulse or a
  // queued one.
  assign launch = (state_reg == IDLE) && (pulse_in || (pending_reg != '0));

  // A fresh pulse that launches directly with nothing queued bypasses the
  // counter; otherwise it is queued. A launch with work queued consumes one.
  assign pend_inc = pulse_in && !(launch && (pending_reg == '0));
  assign pend_dec = launch && (pending_reg != '0);

  // Normal progress out of the current phase (ack has the final word over an
  // expiring phase counter on the same edge).
  assign hs_advance = ((state_reg == REQ) && ack_s) ||
                      ((state_reg == RELEASE) && !ack_s);

  always_comb begin
    pending_next  = pending_reg;
    overflow_next = overflow_reg;
    if (pend_inc && !pend_dec) begin
      if (pending_reg == PEND_MAX) begin
        overflow_next = 1'b1;
      end else begin
        pending_next = pending_reg + CNT_W'(1);
      end
    end else if (pend_dec && !pend_inc) begin
      pending_next = pending_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      req_reg      <= 1'b0;
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
      case (state_reg)
        IDLE: begin
          // ack_s left high by a stray far-side ack is ignored here; REQ
          // below waits for it like any other ack.
          if (launch) begin
            state_reg <= REQ;
            req_reg   <= 1'b1;
          end
        end
        REQ: begin
          if (ack_s) begin
            state_reg <= RELEASE;
            req_reg   <= 1'b0;
          end else if (phase_expired) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
          end
        end
        RELEASE: begin
          if (!ack_s || phase_expired) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

`ifdef HS_TIMEOUT_EN
  localparam int              PH_W    = phase_cnt_w(TIMEOUT_CYCLES);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(TIMEOUT_CYCLES - 1);

  logic [PH_W-1:0] phase_cnt_reg;
  logic            timeout_reg;

  // The counter holds the number of cycles already spent in the current
  // phase, so reaching PH_LAST on a non-advancing edge means this edge would
  // complete TIMEOUT_CYCLES cycles in the phase.
  assign phase_expired = (state_reg != IDLE) && !hs_advance &&
                         (phase_cnt_reg == PH_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      if (launch || hs_advance || phase_expired) begin
        phase_cnt_reg <= '0;
      end else if (state_reg != IDLE) begin
        phase_cnt_reg <= phase_cnt_reg + PH_W'(1);
      end
      if (phase_expired) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign timeout = timeout_reg;
`else
  logic unused_timeout_cfg;

  // Keeps the phase-limit parameter referenced when the feature is compiled
  // out; it has no effect on the logic.
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign phase_expired      = 1'b0;
  assign timeout            = 1'b0;
`endif

  assign req_out  = req_reg;
  assign busy     = (state_reg != IDLE);
  assign pending  = pending_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_enable_handshake_tx.sv
`timescale 1ns/1ps

module tb_enable_handshake_tx;

  localparam int SS   = 2;
  localparam int CW   = 4;
  localparam int MAXP = (1 << CW) - 1;
`ifdef HS_TIMEOUT_EN
  localparam int TMO  = 20;
`else
  localparam int TMO  = 1023;
`endif

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          pulse_in = 1'b0;
  logic          ack_in;
  logic          req_out;
  logic          busy;
  logic [CW-1:0] pending;
  logic          overflow;
  logic          timeout;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #15.625 clk = ~clk;

  enable_handshake_tx #(
    .SYNC_STAGES    (SS),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .ack_in   (ack_in),
    .req_out  (req_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow),
    .timeout  (timeout)
  );

  // Far side: ack echoes req_out three cycles later; ack_block holds it low.
  logic [2:0] ack_pipe  = 3'b000;
  logic       ack_block = 1'b0;
  always @(posedge clk) ack_pipe <= {ack_pipe[1:0], req_out};
  assign ack_in = ack_pipe[2] & ~ack_block;

  // ---------------------------------------------------------------------------
  // Behavioural model: work conservation on an unbounded integer backlog
  // (clamped at MAXP), a phase number 0/1/2 for idle/requesting/releasing,
  // an age in cycles for the phase limit, and a history of ack_in samples.
  // ---------------------------------------------------------------------------
  int          m_phase   = 0;
  int          m_backlog = 0;
  int          m_age     = 0;
  bit          m_ovf     = 1'b0;
  bit          m_tmo     = 1'b0;
  bit [SS-1:0] m_hist    = '0;

  always @(posedge clk or negedge reset) begin : model
    int total;
    int nphase;
    int nage;
    bit ack_seen;
    bit go;
    if (!reset) begin
      m_phase   <= 0;
      m_backlog <= 0;
      m_age     <= 0;
      m_ovf     <= 1'b0;
      m_tmo     <= 1'b0;
      m_hist    <= '0;
    end else begin
      ack_seen = m_hist[SS-1];
      go       = (m_phase == 0) && (pulse_in || m_backlog > 0);
      total    = m_backlog + (pulse_in ? 1 : 0) - (go ? 1 : 0);
      if (total > MAXP) begin
        m_backlog <= MAXP;
        m_ovf     <= 1'b1;
      end else begin
        m_backlog <= total;
      end
      nphase = m_phase;
      if (m_phase == 0 && go) nphase = 1;
      else if (m_phase == 1 && ack_seen) nphase = 2;
      else if (m_phase == 2 && !ack_seen) nphase = 0;
      nage = m_age + 1;
      if (nphase != m_phase) nage = 0;
`ifdef HS_TIMEOUT_EN
      else if (m_phase != 0 && nage >= TMO) begin
        nphase = 0;
        nage   = 0;
        m_tmo <= 1'b1;
      end
`endif
      m_phase <= nphase;
      m_age   <= nage;
      m_hist  <= {m_hist[SS-2:0], ack_in};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_req_out",  32'(req_out),  32'(m_phase == 1));
      check("cyc_busy",     32'(busy),     32'(m_phase != 0));
      check("cyc_pending",  32'(pending),  32'(m_backlog));
      check("cyc_overflow", 32'(overflow), 32'(m_ovf));
      check("cyc_timeout",  32'(timeout),  32'(m_tmo));
    end
  end

  // Handshake counters observed on the DUT pins.
  int   rise_cnt = 0;
  int   hi_cnt   = 0;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (req_out === 1'b1 && req_prev === 1'b0) rise_cnt <= rise_cnt + 1;
    if (req_out === 1'b1) hi_cnt <= hi_cnt + 1;
    req_prev <= req_out;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulses(input int n);
    pulse_in = 1'b1;
    repeat (n) step();
    pulse_in = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || pending != '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy || pending != '0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: still busy after %0d cycles (pending=%0d), required idle", name, budget, pending);
    end
    repeat (8) @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "time limit");
  end

  initial begin : stim
    int base;
    int n;

    // Reset: 5 cycles low, then release.
    #5 reset = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("rst_req_out",  32'(req_out),  0);
    check("rst_busy",     32'(busy),     0);
    check("rst_pending",  32'(pending),  0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_timeout",  32'(timeout),  0);
    reset  = 1'b1;
    chk_en = 1'b1;
    step();
    $display("reset released: req_out=%0d busy=%0d pending=%0d", req_out, busy, pending);

    // Single pulse: req_out high right after the edge that sees the pulse.
    base = rise_cnt;
    pulses(1);
    check("single_req",  32'(req_out), 1);
    check("single_busy", 32'(busy),    1);
    check("single_pend", 32'(pending), 0);
    wait_idle("single_idle", 200);
    check("single_rises", 32'(rise_cnt - base), 1);
    $display("single pulse: handshakes=%0d pending=%0d", rise_cnt - base, pending);

    // Burst of 5: first bypasses, four queue.
    base = rise_cnt;
    pulses(5);
    check("burst_pend_peak", 32'(pending), 4);
    wait_idle("burst_idle", 500);
    check("burst_rises",    32'(rise_cnt - base), 5);
    check("burst_pend_end", 32'(pending),  0);
    check("burst_overflow", 32'(overflow), 0);
    $display("burst of 5: handshakes=%0d overflow=%0d", rise_cnt - base, overflow);

    // Saturation: 20 pulses with ack held low.
    ack_block = 1'b1;
    base = rise_cnt;
    pulses(20);
    check("sat_pend",     32'(pending),  15);
    check("sat_overflow", 32'(overflow), 1);
    check("sat_req",      32'(req_out),  1);
    ack_block = 1'b0;
    wait_idle("sat_idle", 3000);
    check("sat_rises",    32'(rise_cnt - base), 16);
    check("sat_ovf_held", 32'(overflow), 1);
    $display("saturation: handshakes=%0d overflow=%0d", rise_cnt - base, overflow);

    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    check("sat_ovf_cleared", 32'(overflow), 0);

    // Pulse on the same edge as a launch from pending=3.
    ack_block = 1'b1;
    base = rise_cnt;
    pulses(4);
    check("simul_pend_pre", 32'(pending), 3);
    ack_block = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("simul_found_idle", 32'(busy), 0);
    pulse_in = 1'b1;
    @(posedge clk);
    #2;
    pulse_in = 1'b0;
    check("simul_pend", 32'(pending), 3);
    check("simul_req",  32'(req_out), 1);
    wait_idle("simul_idle", 500);
    check("simul_rises", 32'(rise_cnt - base), 5);
    $display("simultaneous launch+pulse: pending held, handshakes=%0d", rise_cnt - base);

    // Asynchronous reset in the middle of REQ.
    pulses(3);
    check("mid_req_pre",  32'(req_out), 1);
    check("mid_pend_pre", 32'(pending), 2);
    #5 reset = 1'b0;
    #1;
    check("mid_req_async",  32'(req_out), 0);
    check("mid_pend_async", 32'(pending), 0);
    check("mid_busy_async", 32'(busy),    0);
    step();
    step();
    reset = 1'b1;
    base = rise_cnt;
    repeat (20) step();
    check("mid_no_req", 32'(rise_cnt - base), 0);
    $display("reset mid-REQ: req_out=%0d pending=%0d later handshakes=%0d", req_out, pending, rise_cnt - base);

`ifdef HS_TIMEOUT_EN
    // Phase limit: ack stuck low.
    ack_block = 1'b1;
    base = hi_cnt;
    pulses(1);
    n = 0;
    while (!timeout && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_flag",     32'(timeout), 1);
    check("tmo_req_low",  32'(req_out), 0);
    check("tmo_idle",     32'(busy),    0);
    check("tmo_req_cyc",  32'(hi_cnt - base), 20);
    step();
    pulses(1);
    check("tmo_relaunch", 32'(req_out), 1);
    ack_block = 1'b0;
    wait_idle("tmo_idle_end", 300);
    check("tmo_sticky",   32'(timeout), 1);
    $display("phase limit: req cycles=%0d timeout=%0d", hi_cnt - base, timeout);
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
